// File: rtl/dbuf_pkg.sv
// Shared types and defaults for the ping-pong frame streamer.
package dbuf_pkg;

    localparam int unsigned DEF_AWIDTH    = 11;
    localparam int unsigned DEF_NUM_WORDS = 2048;
    localparam int unsigned DEF_DWIDTH    = 60;
    localparam int unsigned FIFO_DEPTH    = 2;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    function automatic logic bank_readable(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/dbuf_bank_ram.sv
// Simple dual-port RAM holding both banks; address is {bank, word}, read data registered.
module dbuf_bank_ram
    import dbuf_pkg::*;
#(
    parameter int unsigned AWIDTH = DEF_AWIDTH + 1,
    parameter int unsigned DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dbuf_frame_streamer.sv
// Ping-pong frame buffer: producer fills one bank while the consumer drains the other
// through a 2-entry output FIFO whose head can bypass straight from the RAM read register.
module dbuf_frame_streamer
    import dbuf_pkg::*;
#(
    parameter int unsigned AWIDTH    = DEF_AWIDTH,
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
    parameter int unsigned DWIDTH    = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH:0]   frame_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        bank_full
);

    localparam int unsigned LWIDTH = AWIDTH + 1;

    bank_state_t       bank_st  [2];
    logic [LWIDTH-1:0] bank_len [2];
    logic              wr_bank;
    logic              rd_bank;
    logic [AWIDTH-1:0] wr_addr;
    logic [AWIDTH-1:0] rd_addr;
    logic              inflight;
    logic              inflight_last;
    logic [DWIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [1:0]        fifo_count;
    logic [DWIDTH-1:0] ram_q;

    function automatic logic [LWIDTH-1:0] clamp_len(input logic [LWIDTH-1:0] len);
        if ((len == '0) || (len > LWIDTH'(NUM_WORDS))) begin
            return LWIDTH'(NUM_WORDS);
        end
        return len;
    endfunction

    // Write side: length is taken from frame_len only on the first word into an empty bank
    logic              in_fire;
    logic              wr_last;
    logic [LWIDTH-1:0] wr_len;

    assign in_ready = (bank_st[wr_bank] == BANK_EMPTY) || (bank_st[wr_bank] == BANK_FILLING);
    assign in_fire  = in_valid && in_ready;
    assign wr_len   = (bank_st[wr_bank] == BANK_EMPTY) ? clamp_len(frame_len) : bank_len[wr_bank];
    assign wr_last  = ({1'b0, wr_addr} == (wr_len - LWIDTH'(1)));

    // Read side: FIFO occupancy plus the outstanding read never exceeds the FIFO depth
    logic              rd_issue;
    logic              rd_last;
    logic [LWIDTH-1:0] rd_len;

    assign rd_len   = bank_len[rd_bank];
    assign rd_issue = bank_readable(bank_st[rd_bank])
                      && ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
    assign rd_last  = ({1'b0, rd_addr} == (rd_len - LWIDTH'(1)));

    // Output head is the oldest FIFO entry, or the fresh RAM word when the FIFO is empty
    logic head_fifo;
    logic out_fire;
    logic push;
    logic pop;
    logic push_slot;

    assign head_fifo = (fifo_count != 2'd0);
    assign out_valid = head_fifo || inflight;
    assign out_data  = head_fifo ? fifo_data[0] : (inflight ? ram_q : '0);
    assign out_last  = head_fifo ? fifo_last[0] : inflight_last;
    assign out_fire  = out_valid && out_ready;
    assign pop       = out_fire && head_fifo;
    assign push      = inflight && !(out_fire && !head_fifo);
    assign push_slot = 1'(fifo_count - 2'(pop));

    assign bank_full = {bank_readable(bank_st[1]), bank_readable(bank_st[0])};

    dbuf_bank_ram #(
        .AWIDTH (AWIDTH + 1),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (in_fire),
        .waddr ({wr_bank, wr_addr}),
        .wdata (in_data),
        .re    (rd_issue),
        .raddr ({rd_bank, rd_addr}),
        .rdata (ram_q)
    );

    // Writer and reader never own the same bank, so both updates apply in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                bank_st[i]  <= BANK_EMPTY;
                bank_len[i] <= '0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_count    <= 2'd0;
        end else begin
            if (in_fire) begin
                bank_len[wr_bank] <= wr_len;
                if (wr_last) begin
                    bank_st[wr_bank] <= BANK_FULL;
                    wr_bank          <= ~wr_bank;
                    wr_addr          <= '0;
                end else begin
                    bank_st[wr_bank] <= BANK_FILLING;
                    wr_addr          <= wr_addr + AWIDTH'(1);
                end
            end

            if (rd_issue) begin
                if (rd_last) begin
                    bank_st[rd_bank] <= BANK_EMPTY;
                    rd_bank          <= ~rd_bank;
                    rd_addr          <= '0;
                end else begin
                    bank_st[rd_bank] <= BANK_DRAINING;
                    rd_addr          <= rd_addr + AWIDTH'(1);
                end
            end

            inflight      <= rd_issue;
            inflight_last <= rd_issue && rd_last;

            if (pop) begin
                fifo_data[0] <= fifo_data[1];
                fifo_last[0] <= fifo_last[1];
            end
            if (push) begin
                fifo_data[push_slot] <= ram_q;
                fifo_last[push_slot] <= inflight_last;
            end
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_dbuf_frame_streamer.sv
// Scoreboard bench: accepted input words build expected frames; a monitor checks every output handshake.
module tb_dbuf_frame_streamer;

    localparam int AW = 11;
    localparam int NW = 2048;
    localparam int DW = 60;
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [LW-1:0] frame_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    bank_full;

    int errors = 0;
    int checks = 0;

    logic [DW:0]   exp_q [$];
    logic [DW-1:0] m_frame [$];
    int            m_len = 0;

    int            ready_mode = 0;
    int            pat_idx = 0;
    logic [3:0]    pat = 4'b1001;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW:0]   e;

    always #5 clk = ~clk;

    dbuf_frame_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .frame_len (frame_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .bank_full (bank_full)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int clamp(input int fl);
        return ((fl == 0) || (fl > NW)) ? NW : fl;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    // Reference model: a frame becomes expected output once its final word is accepted
    task automatic model_accept(input logic [DW-1:0] d);
        if (m_frame.size() == 0) m_len = clamp(int'(frame_len));
        m_frame.push_back(d);
        if (m_frame.size() == m_len) begin
            for (int i = 0; i < m_len; i++) exp_q.push_back({(i == m_len - 1), m_frame[i]});
            m_frame.delete();
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d);
                break;
            end
            waited++;
            if (waited > 5000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int flen, input int n);
        frame_len = LW'(flen);
        for (int i = 0; i < n; i++) send_word(rnd());
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((exp_q.size() != 0) || out_valid) && (n < budget));
        check("drain_left", 64'(exp_q.size()), 64'(0));
        check("drain_idle", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Consumer readiness: 1 = random, 2 = repeating 1,0,0,1
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
        end else if (ready_mode == 2) begin
            out_ready = pat[pat_idx[1:0]];
            pat_idx++;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks stall stability
    always @(negedge clk) begin
        if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'(out_data), 64'(prev_data));
            check("hold_last", 64'(out_last), 64'(prev_last));
        end
        prev_stall = !reset && out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e[DW-1:0]));
                check("out_last", 64'(out_last), 64'(e[DW]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_bank_full", 64'(bank_full), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Length-4 frame, latency and back-to-back output
        out_ready = 1'b1;
        frame_len = LW'(4);
        for (int d = 1; d <= 4; d++) send_word(DW'(d));
        @(negedge clk);
        check("lat_t1_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("lat_t2_valid", 64'(out_valid), 64'(1));
        check("lat_t2_data", 64'(out_data), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stream_valid", 64'(out_valid), 64'(1));
        end
        @(negedge clk);
        check("t1_bank_full", 64'(bank_full), 64'(0));
        check("t1_idle", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        // Two frames (3, 5) while blocked, then drain without bubbles
        out_ready = 1'b0;
        send_frame(3, 3);
        send_frame(5, 5);
        @(negedge clk);
        check("both_in_ready", 64'(in_ready), 64'(0));
        check("both_bank_full", 64'(bank_full), 64'(3));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("nobubble_valid", 64'(out_valid), 64'(1));
        end
        wait_drain(100);

        // Stall pattern during a frame
        pat_idx = 0;
        ready_mode = 2;
        send_frame(6, 6);
        wait_drain(200);
        ready_mode = 0;
        out_ready = 1'b1;

        // Randomized frames, gaps and backpressure
        ready_mode = 1;
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 20);
            frame_len = LW'(n);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                send_word(rnd());
            end
        end
        wait_drain(2000);
        ready_mode = 0;
        out_ready = 1'b1;

        // Length clamping: 0 and 3000 both mean 2048
        send_frame(0, NW);
        send_frame(3000, NW);
        wait_drain(5000);

        // Writer completes one bank as the reader releases the other
        send_frame(3, 3);
        send_frame(3, 3);
        @(negedge clk);
        check("sim_one_full", 64'($countones(bank_full)), 64'(1));
        check("sim_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        send_frame(2, 2);
        wait_drain(100);

        // Reset while both banks hold frames
        out_ready = 1'b0;
        send_frame(4, 4);
        send_frame(4, 4);
        @(negedge clk);
        check("prerst_bank_full", 64'(bank_full), 64'(3));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_bank_full", 64'(bank_full), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_out_data", 64'(out_data), 64'(0));
        check("mid_rst_out_last", 64'(out_last), 64'(0));
        exp_q.delete();
        m_frame.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send_frame(2, 2);
        wait_drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbuf_frame_streamer.md
# dbuf_frame_streamer

Double-buffered (ping-pong) frame buffer. A producer writes whole frames over a valid/ready stream into one bank while a consumer drains the previously completed frame from the other bank over a second valid/ready stream. Sits between a compute stage that emits 60-bit result words in bursts and a downstream stage that consumes them at its own rate. It decouples the two sides by one frame of latency.

## Interface
Parameters:
- AWIDTH, 11, address width of one bank
- NUM_WORDS, 2048, words per bank (2**AWIDTH)
- DWIDTH, 60, data word width

Ports (clock and reset: clk; reset is synchronous, active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- frame_len  in  AWIDTH+1  words in next frame; sampled on the first accepted input word of a frame
- in_valid  in  1  producer word valid
- in_ready  out  1  block can accept a word
- in_data  in  DWIDTH  producer word
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts word
- out_data  out  DWIDTH  output word
- out_last  out  1  high with the final word of a frame
- bank_full  out  2  bank i holds a complete, not-yet-fully-read frame

## Operation
- Each bank has its own state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - wr_bank starts at 0. in_ready = 1 iff bank wr_bank is EMPTY or FILLING.
  - On the first handshake into an EMPTY bank: latch the length (0 or >NUM_WORDS clamps to NUM_WORDS), write address 0, state becomes FILLING.
  - Each handshake writes in_data at wr_addr and increments wr_addr.
  - On the handshake with wr_addr == len-1: bank becomes FULL, wr_bank toggles, wr_addr resets to 0.
- Read side:
  - rd_bank starts at 0.
  - When bank rd_bank is FULL, it becomes DRAINING and reads issue at rd_addr = 0,1,...
  - A read is issued only when output FIFO occupancy plus in-flight reads is less than 2.
  - When the read of address len-1 is issued, the bank becomes EMPTY (its data is already captured) and rd_bank toggles.
  - Read data carries a last tag into a 2-entry output FIFO. The FIFO head drives out_valid, out_data and out_last.
- bank_full[i] = 1 in states FULL and DRAINING.
- Simultaneous events:
  - The writer finishing bank A and the reader releasing bank B in the same cycle are both applied.
  - A bank released by the reader in cycle N may accept a write in cycle N+1.
- The block never drops or duplicates a word, and never reads a bank that is not FULL or DRAINING.
- Reset mid-operation discards all frames: banks EMPTY, pointers 0, FIFO empty.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0, out_last = 0, out_data = 0
  - bank_full = 2'b00
- RAM read latency is 1 cycle.
- Frame latency: last input handshake in cycle T -> bank FULL in T+1 -> first read in T+1 -> out_valid = 1 in T+2.
- Throughput:
  - 1 word/cycle sustained on each side while out_ready = 1.
  - No bubble between consecutive frames if the next bank is FULL before the last read of the current frame is issued.
- Backpressure: when out_ready = 0, out_data and out_last hold stable and out_valid stays 1.
- in_ready deasserts combinationally from registered bank state only. There is no combinational path from out_ready to in_ready.

## Structure
- Package dbuf_pkg:
  - bank state enum (EMPTY, FILLING, FULL, DRAINING)
  - default AWIDTH, DWIDTH, NUM_WORDS
  - FIFO depth constant (2)
- One sub-module, dbuf_bank_ram:
  - simple dual-port RAM, one write port and one read port, depth 2*NUM_WORDS
  - address = {bank, addr}
  - registered read output
- The controller holds the bank state machines, pointers, length registers, the in-flight bit and the 2-entry output FIFO.

## Test plan
- Reset, frame_len = 4, write 0x1..0x4 back-to-back with out_ready = 1 -> last write at T, out_valid at T+2, data 0x1..0x4 on consecutive cycles, out_last only with 0x4, bank_full returns to 00.
- Two frames, length 3 and 5, written with no gap while out_ready = 0 -> after both frames in_ready = 0 and bank_full = 11. Raise out_ready -> 8 words out in order, zero bubbles, out_last on words 3 and 8.
- Stall: out_ready toggles 1,0,0,1 during a frame -> out_data held stable while stalled, no loss or duplication.
- frame_len = 0 -> frame accepted as 2048 words, out_last on word 2048. frame_len = 3000 -> clamped to 2048.
- Writer completes a frame in the same cycle the reader releases the other bank -> both state changes applied; a write to the released bank is accepted the next cycle.
- Assert reset mid-drain with bank_full = 11 -> next cycle out_valid = 0, bank_full = 00, in_ready = 1. A fresh length-2 frame then streams correctly.
